cva6_mem_req_arbiter: RTL and testbench
=======================================

// Module: cva6_mem_req_arbiter
// PURPOSE
//  Shares the single cache-to-NoC memory request port between NrPorts requesters
//  (0: icache refill, 1: dcache load miss, 2: write-buffer store).
//  - Round-robin arbitration; each accepted request gets a transaction ID (TID).
//  - Return packets are routed back to the requester that owns the TID.
//  - Write-through stores in flight are capped at MaxOutstandingStores.
//  - A drain (fence) handshake is provided. Sits between the caches and the AXI adapter.
// PARAMETERS
//  NrPorts              3   number of requesters (2..4)
//  AddrWidth           64   request address width
//  DataWidth           64   store data width
//  TidWidth             2   TID width; pool holds 2**TidWidth entries
//  MaxOutstandingStores 7   store-in-flight cap (1..15)
// PORTS
//  clk_i             in   1                   clock
//  rst_ni            in   1                   reset, synchronous, active-low
//  req_valid_i       in   NrPorts             per-port request valid
//  req_ready_o       out  NrPorts             per-port accept (one-hot or zero)
//  req_we_i          in   NrPorts             1 = store, 0 = load/refill
//  req_addr_i        in   NrPorts*AddrWidth   packed addresses; port p at [p*AddrWidth +: AddrWidth]
//  req_wdata_i       in   NrPorts*DataWidth   packed store data
//  mem_valid_o       out  1                   downstream request valid
//  mem_ready_i       in   1                   downstream accept
//  mem_we_o          out  1                   issued request is a store
//  mem_addr_o        out  AddrWidth           issued address
//  mem_wdata_o       out  DataWidth           issued store data
//  mem_tid_o         out  TidWidth            issued TID
//  rtrn_valid_i      in   1                   return packet valid
//  rtrn_tid_i        in   TidWidth            return packet TID
//  rtrn_valid_o      out  NrPorts             return routed to owning port (one-hot)
//  drain_req_i       in   1                   level: stop issuing, wait for empty
//  drain_done_o      out  1                   all TIDs free while draining
//  unexp_rtrn_o      out  1                   1-cycle pulse: return on a free TID
//  perf_stall_o      out  32                  stall-cycle counter (optional feature)
// BEHAVIOUR
//  Reset (rst_ni=0 at a clk_i edge):
//   - state=IDLE, all TIDs free, store count=0, RR pointer=0.
//   - mem_valid_o=0, req_ready_o=0, rtrn_valid_o=0, drain_done_o=0, unexp_rtrn_o=0, perf_stall_o=0.
//   - Reset mid-transaction discards the held request and the TID table.
//  Eligible port p: req_valid_i[p], a free TID exists, and (!req_we_i[p] or store count < MaxOutstandingStores).
//  Capture is allowed in IDLE, or in ISSUE in the same cycle mem_ready_i=1 (back-to-back, 1 req/cycle).
//   - Winner = first eligible port at or after the RR pointer; req_ready_o[winner]=1 (combinational).
//   - Registers we/addr/wdata and allocates the lowest-index free TID, recording owner port and we.
//   - A store increments store count. RR pointer <- (winner+1) mod NrPorts.
//   - Next state ISSUE; mem_valid_o=1 on the following cycle (1-cycle latency).
//  ISSUE: mem_* outputs held stable while mem_valid_o && !mem_ready_i. On mem_ready_i:
//   - capture again if allowed; otherwise go to IDLE, or DRAIN if drain_req_i=1.
//  DRAIN (entered from IDLE when drain_req_i=1, or from ISSUE on completion): no captures.
//   - drain_done_o = all TIDs free (combinational).
//   - drain_req_i=0 -> IDLE.
//  Return, rtrn_valid_i with allocated TID t:
//   - rtrn_valid_o[owner(t)]=1 in the same cycle; t is freed at the clock edge.
//   - A freed store TID decrements store count.
//   - A freed TID is allocatable from the next cycle, never the same cycle.
//  Return, rtrn_valid_i with free TID: no routing; unexp_rtrn_o pulses on the next cycle; state unchanged.
//  Store alloc and store return in the same cycle: store count unchanged.
//  All TIDs busy: req_ready_o=0, no capture; requesters keep valid asserted.
//  Store count == MaxOutstandingStores: stores blocked; loads still eligible.
// CONFIGURATION
//  MEM_ARB_PERF_CNT_EN defined:
//   - perf_stall_o counts cycles with any req_valid_i=1 and no req_ready_o.
//   - Saturates at 32'hFFFF_FFFF.
//  MEM_ARB_PERF_CNT_EN undefined: perf_stall_o tied to 0, no counter flops.
// TESTING
//  1. Ports 0,1,2 valid every cycle, mem_ready_i=1 -> grants in order 0,1,2,0; TIDs 0,1,2,3; then stall until a return.
//  2. mem_ready_i=0 for 5 cycles with request held -> mem_addr_o/mem_tid_o unchanged; accepted on cycle 6.
//  3. Port 2 issues 7 stores with no returns -> 8th store blocked while a port-1 load is still granted.
//     Return of a store TID -> store granted on the next cycle.
//  4. rtrn_valid_i with tid=1 owned by port 1 -> rtrn_valid_o=3'b010 same cycle.
//     rtrn_tid_i=2 while TID 2 is free -> unexp_rtrn_o=1 one cycle later.
//  5. drain_req_i=1 with 3 TIDs busy -> no grants, drain_done_o=0.
//     After the 3 returns -> drain_done_o=1; drop drain_req_i -> grants resume.
//  6. rst_ni=0 while in ISSUE with 4 TIDs busy -> next cycle mem_valid_o=0, all TIDs free.
//     With the macro defined, 10 blocked cycles -> perf_stall_o=10.

Source files
------------

// File: rtl/cva6_mem_req_arbiter.sv
// Round-robin arbiter sharing one memory request port between NrPorts requesters, with TID
// allocation, return routing, a store-in-flight cap and a drain handshake. Optional: MEM_ARB_PERF_CNT_EN.
module cva6_mem_req_arbiter #(
  parameter int unsigned NrPorts              = 3,
  parameter int unsigned AddrWidth            = 64,
  parameter int unsigned DataWidth            = 64,
  parameter int unsigned TidWidth             = 2,
  parameter int unsigned MaxOutstandingStores = 7
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NrPorts-1:0]             req_valid_i,
  output logic [NrPorts-1:0]             req_ready_o,
  input  logic [NrPorts-1:0]             req_we_i,
  input  logic [NrPorts*AddrWidth-1:0]   req_addr_i,
  input  logic [NrPorts*DataWidth-1:0]   req_wdata_i,
  output logic                           mem_valid_o,
  input  logic                           mem_ready_i,
  output logic                           mem_we_o,
  output logic [AddrWidth-1:0]           mem_addr_o,
  output logic [DataWidth-1:0]           mem_wdata_o,
  output logic [TidWidth-1:0]            mem_tid_o,
  input  logic                           rtrn_valid_i,
  input  logic [TidWidth-1:0]            rtrn_tid_i,
  output logic [NrPorts-1:0]             rtrn_valid_o,
  input  logic                           drain_req_i,
  output logic                           drain_done_o,
  output logic                           unexp_rtrn_o,
  output logic [31:0]                    perf_stall_o
);
  localparam int unsigned NumTids  = 2 ** TidWidth;
  localparam int unsigned PortW    = $clog2(NrPorts);
  localparam logic [3:0]  StoreCap = 4'(MaxOutstandingStores);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;
  state_e state_q, state_d;

  logic [NumTids-1:0] busy_q;
  logic [NumTids-1:0] store_q;
  logic [PortW-1:0]   owner_q [NumTids];
  logic [3:0]         store_cnt_q;
  logic [PortW-1:0]   rr_q;
  logic               unexp_q;

  logic                 mem_we_q;
  logic [AddrWidth-1:0] mem_addr_q;
  logic [DataWidth-1:0] mem_wdata_q;
  logic [TidWidth-1:0]  mem_tid_q;

  logic                 any_free;
  logic [TidWidth-1:0]  free_tid;
  logic [NrPorts-1:0]   eligible;
  logic                 winner_found;
  logic [PortW-1:0]     winner;
  logic [PortW-1:0]     scan_idx;
  logic                 capture_ok;
  logic                 capture;
  logic                 rtrn_hit;
  logic                 alloc_store;
  logic                 free_store;

  // Lowest-index free TID; a TID freed this cycle is still busy here.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    any_free = 1'b0;
    free_tid = '0;
    for (int t = int'(NumTids) - 1; t >= 0; t--) begin
      if (!busy_q[t]) begin
        any_free = 1'b1;
        free_tid = TidWidth'(t);
      end
    end
  end

  always_comb begin
    for (int p = 0; p < int'(NrPorts); p++) begin
      eligible[p] = req_valid_i[p] && any_free && (!req_we_i[p] || (store_cnt_q < StoreCap));
    end
  end

  // First eligible port at or after the round-robin pointer.
  always_comb begin
    winner_found = 1'b0;
    winner       = '0;
    scan_idx     = rr_q;
    for (int k = 0; k < int'(NrPorts); k++) begin
      if (!winner_found && eligible[scan_idx]) begin
        winner_found = 1'b1;
        winner       = scan_idx;
      end
      scan_idx = (scan_idx == PortW'(NrPorts - 1)) ? '0 : scan_idx + PortW'(1);
    end
  end

  // A pending drain blocks new captures in every state.
  assign capture_ok  = rst_ni && !drain_req_i &&
                       ((state_q == IDLE) || ((state_q == ISSUE) && mem_ready_i));
  assign capture     = capture_ok && winner_found;
  assign rtrn_hit    = rtrn_valid_i && busy_q[rtrn_tid_i];
  assign alloc_store = capture && req_we_i[winner];
  assign free_store  = rtrn_hit && store_q[rtrn_tid_i];

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (capture)          state_d = ISSUE;
        else if (drain_req_i) state_d = DRAIN;
      end
      ISSUE: begin
        if (mem_ready_i) begin
          if (capture)          state_d = ISSUE;
          else if (drain_req_i) state_d = DRAIN;
          else                  state_d = IDLE;
        end
      end
      DRAIN: if (!drain_req_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = '0;
    if (capture) req_ready_o[winner] = 1'b1;
    rtrn_valid_o = '0;
    if (rtrn_hit && rst_ni) rtrn_valid_o[owner_q[rtrn_tid_i]] = 1'b1;
    mem_valid_o  = (state_q == ISSUE);
    drain_done_o = (state_q == DRAIN) && !(|busy_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q      <= '0;
      store_q     <= '0;
      store_cnt_q <= '0;
      rr_q        <= '0;
      unexp_q     <= 1'b0;
    end else begin
      unexp_q <= rtrn_valid_i && !busy_q[rtrn_tid_i];
      if (rtrn_hit) busy_q[rtrn_tid_i] <= 1'b0;
      if (capture) begin
        busy_q[free_tid]  <= 1'b1;
        store_q[free_tid] <= req_we_i[winner];
        rr_q              <= (winner == PortW'(NrPorts - 1)) ? '0 : winner + PortW'(1);
      end
      if (alloc_store && !free_store)      store_cnt_q <= store_cnt_q + 4'd1;
      else if (!alloc_store && free_store) store_cnt_q <= store_cnt_q - 4'd1;
    end
  end

  // NOTE: payload and owner table are always qualified by state/busy bits, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (capture) begin
      owner_q[free_tid] <= winner;
      mem_we_q          <= req_we_i[winner];
      mem_addr_q        <= req_addr_i[winner*AddrWidth +: AddrWidth];
      mem_wdata_q       <= req_wdata_i[winner*DataWidth +: DataWidth];
      mem_tid_q         <= free_tid;
    end
  end

  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign mem_tid_o    = mem_tid_q;
  assign unexp_rtrn_o = unexp_q;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      perf_q <= '0;
    end else if ((|req_valid_i) && !(|req_ready_o) && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end
  assign perf_stall_o = perf_q;
`else
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_cva6_mem_req_arbiter.sv
// Directed bench for cva6_mem_req_arbiter: issued requests are checked by a scoreboard monitor,
// grants/returns/drain/reset by inline checks. Uses an 8-entry TID pool so the store cap of 7 is reachable.
module tb_cva6_mem_req_arbiter;
  localparam int NP = 3;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TW = 3;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [TW-1:0] tid;
  } txn_t;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic [NP-1:0]    req_valid_i;
  logic [NP-1:0]    req_ready_o;
  logic [NP-1:0]    req_we_i;
  logic [NP*AW-1:0] req_addr_i;
  logic [NP*DW-1:0] req_wdata_i;
  logic             mem_valid_o;
  logic             mem_ready_i;
  logic             mem_we_o;
  logic [AW-1:0]    mem_addr_o;
  logic [DW-1:0]    mem_wdata_o;
  logic [TW-1:0]    mem_tid_o;
  logic             rtrn_valid_i;
  logic [TW-1:0]    rtrn_tid_i;
  logic [NP-1:0]    rtrn_valid_o;
  logic             drain_req_i;
  logic             drain_done_o;
  logic             unexp_rtrn_o;
  logic [31:0]      perf_stall_o;

  txn_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   exp_perf;

  cva6_mem_req_arbiter #(.NrPorts(NP), .AddrWidth(AW), .DataWidth(DW), .TidWidth(TW),
                         .MaxOutstandingStores(7)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_tid_o(mem_tid_o),
    .rtrn_valid_i(rtrn_valid_i), .rtrn_tid_i(rtrn_tid_i), .rtrn_valid_o(rtrn_valid_o),
    .drain_req_i(drain_req_i), .drain_done_o(drain_done_o), .unexp_rtrn_o(unexp_rtrn_o),
    .perf_stall_o(perf_stall_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int p);
    return 64'(p + 1) << 28;
  endfunction

  function automatic logic [DW-1:0] wdata_of(input int p);
    return 64'hD000 + 64'(p);
  endfunction

  task automatic set_req(input int p, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid_i[p]         = v;
    req_we_i[p]            = we;
    req_addr_i[p*AW +: AW] = a;
    req_wdata_i[p*DW +: DW] = d;
  endtask

  task automatic expect_issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input int tid);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d; t.tid = TW'(tid);
    sb.push_back(t);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_return(input string name, input int tid, input logic [NP-1:0] route);
    rtrn_valid_i = 1'b1;
    rtrn_tid_i   = TW'(tid);
    @(negedge clk);
    check(name, rtrn_valid_o, route);
    next_cycle();
    rtrn_valid_i = 1'b0;
  endtask

  // Scoreboard monitor: the held request must match the queue head every cycle it is presented.
  always @(negedge clk) begin
    if (rst_ni && mem_valid_o) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL issue_unexpected: got tid %0d expected no request", mem_tid_o);
      end else begin
        check("issue_we", mem_we_o, sb[0].we);
        check("issue_addr", mem_addr_o, sb[0].addr);
        check("issue_wdata", mem_wdata_o, sb[0].wdata);
        check("issue_tid", mem_tid_o, sb[0].tid);
        if (mem_ready_i) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni = 1'b0; req_valid_i = '0; req_we_i = '0; req_addr_i = '0; req_wdata_i = '0;
    mem_ready_i = 1'b0; rtrn_valid_i = 1'b0; rtrn_tid_i = '0; drain_req_i = 1'b0;
    next_cycle();
    next_cycle();
    rst_ni = 1'b1;

    @(negedge clk);
    check("rst_mem_valid", mem_valid_o, 0);
    check("rst_ready", req_ready_o, 0);
    check("rst_drain_done", drain_done_o, 0);
    check("rst_unexp", unexp_rtrn_o, 0);
    check("rst_perf", perf_stall_o, 0);
    next_cycle();

    // Round-robin loads fill the pool, then everything stalls.
    mem_ready_i = 1'b1;
    for (int p = 0; p < NP; p++) set_req(p, 1'b1, 1'b0, addr_of(p), wdata_of(p));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("t1_grant%0d", i), req_ready_o, 64'(1 << (i % 3)));
      expect_issue(1'b0, addr_of(i % 3), wdata_of(i % 3), i);
      next_cycle();
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t1_pool_full", req_ready_o, 0);
      next_cycle();
    end
    for (int p = 0; p < NP; p++) set_req(p, 1'b0, 1'b0, '0, '0);

    // Return routing and unexpected returns.
    do_return("t4_route_tid1", 1, 3'b010);
    do_return("t4_route_tid2", 2, 3'b100);
    rtrn_valid_i = 1'b1; rtrn_tid_i = 3'd2;
    @(negedge clk);
    check("t4_free_no_route", rtrn_valid_o, 0);
    check("t4_unexp_not_yet", unexp_rtrn_o, 0);
    next_cycle();
    rtrn_valid_i = 1'b0;
    @(negedge clk);
    check("t4_unexp_pulse", unexp_rtrn_o, 1);
    next_cycle();
    @(negedge clk);
    check("t4_unexp_clear", unexp_rtrn_o, 0);
    next_cycle();
    for (int t = 0; t < 8; t++) begin
      if (t != 1 && t != 2) do_return($sformatf("t4_route_tid%0d", t), t, 3'(1 << (t % 3)));
    end

    // Downstream backpressure holds the request; port 1 waits.
    mem_ready_i = 1'b0;
    set_req(0, 1'b1, 1'b0, 64'hBEEF_0000, 64'h55);
    @(negedge clk);
    check("t2_grant", req_ready_o, 3'b001);
    expect_issue(1'b0, 64'hBEEF_0000, 64'h55, 0);
    next_cycle();
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b1, 1'b0, addr_of(1), wdata_of(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_valid_held", mem_valid_o, 1);
      check("t2_stall_no_grant", req_ready_o, 0);
      next_cycle();
    end
    mem_ready_i = 1'b1;
    @(negedge clk);
    check("t2_accept_and_grant", req_ready_o, 3'b010);
    expect_issue(1'b0, addr_of(1), wdata_of(1), 1);
    next_cycle();
    set_req(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("t2_idle_no_grant", req_ready_o, 0);
    next_cycle();
    do_return("t2_route_tid0", 0, 3'b001);
    do_return("t2_route_tid1", 1, 3'b010);

    // Store cap: seven stores, the eighth waits, a load still goes.
    for (int i = 0; i < 7; i++) begin
      set_req(2, 1'b1, 1'b1, 64'h3000_0000 + 64'(i * 8), 64'hA000 + 64'(i));
      @(negedge clk);
      check($sformatf("t3_store_grant%0d", i), req_ready_o, 3'b100);
      expect_issue(1'b1, 64'h3000_0000 + 64'(i * 8), 64'hA000 + 64'(i), i);
      next_cycle();
    end
    set_req(2, 1'b1, 1'b1, 64'h3000_0038, 64'hA007);
    @(negedge clk);
    check("t3_store_cap_blocks", req_ready_o, 0);
    next_cycle();
    set_req(1, 1'b1, 1'b0, 64'h2222_0000, 64'h77);
    @(negedge clk);
    check("t3_load_past_cap", req_ready_o, 3'b010);
    expect_issue(1'b0, 64'h2222_0000, 64'h77, 7);
    next_cycle();
    set_req(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("t3_pool_full", req_ready_o, 0);
    next_cycle();
    rtrn_valid_i = 1'b1; rtrn_tid_i = 3'd3;
    @(negedge clk);
    check("t3_route_store", rtrn_valid_o, 3'b100);
    check("t3_no_same_cycle_realloc", req_ready_o, 0);
    next_cycle();
    rtrn_valid_i = 1'b0;
    @(negedge clk);
    check("t3_store_after_return", req_ready_o, 3'b100);
    expect_issue(1'b1, 64'h3000_0038, 64'hA007, 3);
    next_cycle();
    set_req(2, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("t3_idle_no_grant", req_ready_o, 0);
    next_cycle();
    for (int t = 0; t < 8; t++) do_return($sformatf("t3_route_tid%0d", t), t, (t == 7) ? 3'b010 : 3'b100);

    // Drain with three loads in flight.
    for (int p = 0; p < NP; p++) set_req(p, 1'b1, 1'b0, addr_of(p), wdata_of(p));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t5_grant%0d", i), req_ready_o, 64'(1 << i));
      expect_issue(1'b0, addr_of(i), wdata_of(i), i);
      next_cycle();
    end
    for (int p = 0; p < NP; p++) set_req(p, 1'b0, 1'b0, '0, '0);
    drain_req_i = 1'b1;
    @(negedge clk);
    check("t5_done_low_in_issue", drain_done_o, 0);
    next_cycle();
    set_req(0, 1'b1, 1'b0, addr_of(0), wdata_of(0));
    for (int t = 0; t < 3; t++) begin
      rtrn_valid_i = 1'b1; rtrn_tid_i = TW'(t);
      @(negedge clk);
      check("t5_drain_route", rtrn_valid_o, 64'(1 << t));
      check("t5_drain_no_grant", req_ready_o, 0);
      check("t5_drain_not_done", drain_done_o, 0);
      next_cycle();
    end
    rtrn_valid_i = 1'b0;
    @(negedge clk);
    check("t5_drain_done", drain_done_o, 1);
    check("t5_done_no_grant", req_ready_o, 0);
    next_cycle();
    drain_req_i = 1'b0;
    for (int p = 0; p < NP; p++) set_req(p, 1'b1, 1'b0, addr_of(p), wdata_of(p));
    @(negedge clk);
    check("t5_exit_cycle_no_grant", req_ready_o, 0);
    next_cycle();

    // Resume, fill four TIDs, then reset while a request is held.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("t6_grant%0d", i), req_ready_o, 64'(1 << (i % 3)));
      expect_issue(1'b0, addr_of(i % 3), wdata_of(i % 3), i);
      next_cycle();
    end
    for (int p = 0; p < NP; p++) set_req(p, 1'b0, 1'b0, '0, '0);
    mem_ready_i = 1'b0;
    @(negedge clk);
    check("t6_held_before_reset", mem_valid_o, 1);
    next_cycle();
    rst_ni = 1'b0;
    sb.delete();
    set_req(0, 1'b1, 1'b0, addr_of(0), wdata_of(0));
    @(negedge clk);
    check("t6_no_grant_in_reset", req_ready_o, 0);
    next_cycle();
    rst_ni = 1'b1;
    mem_ready_i = 1'b1;
    for (int p = 0; p < NP; p++) set_req(p, 1'b1, 1'b0, addr_of(p), wdata_of(p));
    @(negedge clk);
    check("t6_mem_valid_after_reset", mem_valid_o, 0);
    check("t6_perf_after_reset", perf_stall_o, 0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("t6_regrant%0d", i), req_ready_o, 64'(1 << (i % 3)));
      expect_issue(1'b0, addr_of(i % 3), wdata_of(i % 3), i);
      next_cycle();
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t6_blocked", req_ready_o, 0);
      next_cycle();
    end
    for (int p = 0; p < NP; p++) set_req(p, 1'b0, 1'b0, '0, '0);
`ifdef MEM_ARB_PERF_CNT_EN
    exp_perf = 10;
`else
    exp_perf = 0;
`endif
    @(negedge clk);
    check("t6_perf_stall", perf_stall_o, 64'(exp_perf));
    next_cycle();

    check("sb_drained", 64'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
